// File: rtl/commit_trace_unit_if.sv
// ============================================================================
// commit_trace_unit_if : trace-record stream between the commit trace unit
//                        and an off-core trace sink (show-ahead valid/ready).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface commit_trace_unit_if;
    logic        rec_valid;
    logic        rec_ready;
    logic [3:0]  rec_flags;
    logic [2:0]  rec_reg;
    logic [15:0] rec_wdata;
    logic [15:0] rec_addr;
    logic [15:0] rec_mdata;
    logic [15:0] rec_cycle;

    modport master (
        output rec_valid, rec_flags, rec_reg, rec_wdata, rec_addr, rec_mdata, rec_cycle,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_flags, rec_reg, rec_wdata, rec_addr, rec_mdata, rec_cycle,
        output rec_ready
    );
endinterface

`default_nettype wire

// File: rtl/commit_trace_unit.sv
// ============================================================================
// commit_trace_unit : packs commit events into trace records, buffers them in
//                     a show-ahead FIFO and keeps run statistics counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module commit_trace_unit #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              reg_wr_i,
    input  wire logic [2:0]        wr_reg_i,
    input  wire logic [15:0]       wr_data_i,
    input  wire logic              mem_rd_i,
    input  wire logic              mem_wr_i,
    input  wire logic [15:0]       mem_addr_i,
    input  wire logic [15:0]       mem_wdata_i,
    input  wire logic [15:0]       mem_rdata_i,
    input  wire logic              halt_i,
    input  wire logic              icache_req_i,
    input  wire logic              icache_hit_i,
    input  wire logic              dcache_req_i,
    input  wire logic              dcache_hit_i,
    commit_trace_unit_if.master    rec,
    output logic                   full_o,
    output logic                   overflow_o,
    output logic                   done_o,
    output logic [CNT_W-1:0]       cycle_count_o,
    output logic [CNT_W-1:0]       inst_count_o,
    output logic [CNT_W-1:0]       icache_req_cnt_o,
    output logic [CNT_W-1:0]       icache_hit_cnt_o,
    output logic [CNT_W-1:0]       dcache_req_cnt_o,
    output logic [CNT_W-1:0]       dcache_hit_cnt_o
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   c_FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0]  flags;
        logic [2:0]  rreg;
        logic [15:0] wdata;
        logic [15:0] addr;
        logic [15:0] mdata;
        logic [15:0] cyc;
    } rec_t;

    state_t            state_q;
    rec_t              fifo_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  cycle_cnt_q, inst_cnt_q;
    logic [CNT_W-1:0]  ic_req_q, ic_hit_q, dc_req_q, dc_hit_q;

    logic  w_run, w_event, w_valid, w_full, w_pop, w_push, w_drop, w_inst;
    rec_t  w_new_rec, w_head;

    assign w_run   = (state_q == S_RUN);
    assign w_event = w_run & (halt_i | reg_wr_i | mem_rd_i | mem_wr_i);
    assign w_inst  = halt_i | reg_wr_i | mem_wr_i;
    assign w_valid = (count_q != '0);
    assign w_full  = (count_q == c_FULL_CNT);
    assign w_pop   = w_valid & rec.rec_ready;
    // A full FIFO can still accept a record when the head leaves on the same edge.
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & w_full & ~w_pop;

    always_comb begin
        w_new_rec.flags = {halt_i, reg_wr_i, mem_rd_i, mem_wr_i};
        w_new_rec.rreg  = wr_reg_i;
        w_new_rec.wdata = wr_data_i;
        w_new_rec.addr  = mem_addr_i;
        w_new_rec.mdata = mem_wr_i ? mem_wdata_i : mem_rdata_i;
        w_new_rec.cyc   = cycle_cnt_q[15:0];
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | w_drop;
        if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head outputs read zero immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (w_push) fifo_q[wr_ptr_q] <= w_new_rec;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
            ic_req_q    <= '0;
            ic_hit_q    <= '0;
            dc_req_q    <= '0;
            dc_hit_q    <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                    inst_cnt_q  <= inst_cnt_q  + CNT_W'(w_inst);
                    ic_req_q    <= ic_req_q    + CNT_W'(icache_req_i);
                    ic_hit_q    <= ic_hit_q    + CNT_W'(icache_hit_i);
                    dc_req_q    <= dc_req_q    + CNT_W'(dcache_req_i);
                    dc_hit_q    <= dc_hit_q    + CNT_W'(dcache_hit_i);
                    if (halt_i) state_q <= S_HALTED;
                end
                default: state_q <= S_HALTED;
            endcase
        end
    end

    assign w_head        = fifo_q[rd_ptr_q];
    assign rec.rec_valid = w_valid;
    assign rec.rec_flags = w_head.flags;
    assign rec.rec_reg   = w_head.rreg;
    assign rec.rec_wdata = w_head.wdata;
    assign rec.rec_addr  = w_head.addr;
    assign rec.rec_mdata = w_head.mdata;
    assign rec.rec_cycle = w_head.cyc;

    assign full_o           = w_full;
    assign overflow_o       = overflow_q;
    assign done_o           = (state_q == S_HALTED) & (count_q == '0);
    assign cycle_count_o    = cycle_cnt_q;
    assign inst_count_o     = inst_cnt_q;
    assign icache_req_cnt_o = ic_req_q;
    assign icache_hit_cnt_o = ic_hit_q;
    assign dcache_req_cnt_o = dc_req_q;
    assign dcache_hit_cnt_o = dc_hit_q;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_unit.sv
// ============================================================================
// tb_commit_trace_unit : directed stimulus with a record scoreboard for the
//                        commit trace unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_commit_trace_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_wr_i = 0, mem_rd_i = 0, mem_wr_i = 0, halt_i = 0;
    logic [2:0]  wr_reg_i = 0;
    logic [15:0] wr_data_i = 0, mem_addr_i = 0, mem_wdata_i = 0, mem_rdata_i = 0;
    logic        icache_req_i = 0, icache_hit_i = 0, dcache_req_i = 0, dcache_hit_i = 0;
    logic        full_o, overflow_o, done_o;
    logic [31:0] cycle_count_o, inst_count_o;
    logic [31:0] icache_req_cnt_o, icache_hit_cnt_o, dcache_req_cnt_o, dcache_hit_cnt_o;

    commit_trace_unit_if rec_if ();

    commit_trace_unit #(.DEPTH(8), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .reg_wr_i         (reg_wr_i),
        .wr_reg_i         (wr_reg_i),
        .wr_data_i        (wr_data_i),
        .mem_rd_i         (mem_rd_i),
        .mem_wr_i         (mem_wr_i),
        .mem_addr_i       (mem_addr_i),
        .mem_wdata_i      (mem_wdata_i),
        .mem_rdata_i      (mem_rdata_i),
        .halt_i           (halt_i),
        .icache_req_i     (icache_req_i),
        .icache_hit_i     (icache_hit_i),
        .dcache_req_i     (dcache_req_i),
        .dcache_hit_i     (dcache_hit_i),
        .rec              (rec_if),
        .full_o           (full_o),
        .overflow_o       (overflow_o),
        .done_o           (done_o),
        .cycle_count_o    (cycle_count_o),
        .inst_count_o     (inst_count_o),
        .icache_req_cnt_o (icache_req_cnt_o),
        .icache_hit_cnt_o (icache_hit_cnt_o),
        .dcache_req_cnt_o (dcache_req_cnt_o),
        .dcache_hit_cnt_o (dcache_hit_cnt_o)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    logic [70:0]  exp_q [$];
    logic [15:0]  tb_cyc = 0;
    bit           tb_halted = 0;

    function automatic void chk(string name, logic [70:0] act, logic [70:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: the record on the bus mid-cycle is the one popped at the next edge.
    always @(negedge clk) begin
        logic [70:0] act;
        if (!rst && rec_if.rec_valid && rec_if.rec_ready) begin
            act = {rec_if.rec_flags, rec_if.rec_reg, rec_if.rec_wdata,
                   rec_if.rec_addr, rec_if.rec_mdata, rec_if.rec_cycle};
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_record: got %0h expected none", act);
            end else begin
                chk("record", act, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (!tb_halted) tb_cyc++;
    endtask

    task automatic ev(input bit exp_push, input logic [3:0] f, input logic [2:0] r,
                      input logic [15:0] wd, input logic [15:0] addr,
                      input logic [15:0] wdat, input logic [15:0] rdat,
                      input logic [15:0] exp_mdata);
        {halt_i, reg_wr_i, mem_rd_i, mem_wr_i} = f;
        wr_reg_i = r; wr_data_i = wd; mem_addr_i = addr;
        mem_wdata_i = wdat; mem_rdata_i = rdat;
        if (exp_push) exp_q.push_back({f, r, wd, addr, exp_mdata, tb_cyc});
        tick();
        if (f[3]) tb_halted = 1;
        {halt_i, reg_wr_i, mem_rd_i, mem_wr_i} = 4'b0000;
        wr_reg_i = 0; wr_data_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_rdata_i = 0;
    endtask

    task automatic reset_dut();
        rec_if.rec_ready = 0;
        rst = 1;
        exp_q.delete();
        tb_cyc = 0;
        tb_halted = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rec_if.rec_ready = 0;
        // Reset state, observed before any clock edge
        #2;
        chk("rst_valid",    rec_if.rec_valid, 0);
        chk("rst_full",     full_o, 0);
        chk("rst_done",     done_o, 0);
        chk("rst_cycle",    cycle_count_o, 0);
        chk("rst_recflags", rec_if.rec_flags, 0);
        reset_dut();

        // Store, load with reg write, and simultaneous rd/wr
        rec_if.rec_ready = 1;
        ev(1, 4'b0001, 3'd0, 16'h0000, 16'h0010, 16'hBEEF, 16'h0000, 16'hBEEF);
        chk("store_inst", inst_count_o, 1);
        chk("store_cycle", cycle_count_o, 1);
        ev(1, 4'b0110, 3'd3, 16'h1234, 16'h0020, 16'h0000, 16'h1234, 16'h1234);
        chk("load_inst", inst_count_o, 2);
        ev(1, 4'b0011, 3'd0, 16'h0000, 16'h0030, 16'hAAAA, 16'h5555, 16'hAAAA);
        chk("rdwr_inst", inst_count_o, 3);
        icache_req_i = 1; icache_hit_i = 1;
        tick();
        icache_hit_i = 0; dcache_req_i = 1; dcache_hit_i = 1;
        tick();
        icache_req_i = 0; dcache_req_i = 0; dcache_hit_i = 0;
        chk("ic_req", icache_req_cnt_o, 2);
        chk("ic_hit", icache_hit_cnt_o, 1);
        chk("dc_req", dcache_req_cnt_o, 1);
        chk("dc_hit", dcache_hit_cnt_o, 1);
        chk("stats_cycle", cycle_count_o, 5);
        chk("stats_inst", inst_count_o, 3);
        tick();
        chk("drain_a", exp_q.size(), 0);

        // Fill to full, drop the ninth, then drain in order
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            ev(i < 8, 4'b0100, 3'(i), 16'h0100 + 16'(i), 16'h0000, 16'h0000, 16'h0000, 16'h0000);
            if (i == 7) begin
                chk("full_after8", full_o, 1);
                chk("ovf_after8", overflow_o, 0);
            end
        end
        chk("ovf_after9", overflow_o, 1);
        rec_if.rec_ready = 1;
        repeat (8) tick();
        chk("drain_valid", rec_if.rec_valid, 0);
        chk("drain_full", full_o, 0);
        chk("ovf_sticky", overflow_o, 1);
        chk("drain_b", exp_q.size(), 0);

        // Push accepted into a full FIFO when the head pops the same cycle
        reset_dut();
        for (int i = 0; i < 8; i++)
            ev(1, 4'b0100, 3'(i), 16'h0200 + 16'(i), 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        chk("full_pre", full_o, 1);
        rec_if.rec_ready = 1;
        ev(1, 4'b0100, 3'd7, 16'hCAFE, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        chk("full_pushpop", full_o, 1);
        chk("ovf_pushpop", overflow_o, 0);
        repeat (8) tick();
        chk("drain_c", exp_q.size(), 0);
        chk("drain_c_valid", rec_if.rec_valid, 0);

        // Halt with three records queued; later inputs are ignored
        reset_dut();
        for (int i = 0; i < 3; i++)
            ev(1, 4'b0100, 3'(i + 1), 16'h0300 + 16'(i), 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        ev(1, 4'b1000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        ev(0, 4'b0100, 3'd5, 16'h0555, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        ev(0, 4'b0100, 3'd6, 16'h0666, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        icache_req_i = 1;
        tick();
        icache_req_i = 0;
        chk("halt_cycle", cycle_count_o, 4);
        chk("halt_inst", inst_count_o, 4);
        chk("halt_icreq", icache_req_cnt_o, 0);
        chk("halt_done_early", done_o, 0);
        rec_if.rec_ready = 1;
        repeat (3) tick();
        chk("halt_done_3pops", done_o, 0);
        tick();
        chk("halt_done_4pops", done_o, 1);
        chk("drain_d", exp_q.size(), 0);

        // Asynchronous reset mid-drain with overflow set
        reset_dut();
        for (int i = 0; i < 9; i++)
            ev(i < 8, 4'b0100, 3'(i), 16'h0400 + 16'(i), 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        rec_if.rec_ready = 1;
        repeat (3) tick();
        rec_if.rec_ready = 0;
        chk("pre_rst_ovf", overflow_o, 1);
        #2;
        rst = 1;
        exp_q.delete();
        #1;
        chk("arst_valid", rec_if.rec_valid, 0);
        chk("arst_ovf", overflow_o, 0);
        chk("arst_full", full_o, 0);
        chk("arst_cycle", cycle_count_o, 0);
        chk("arst_inst", inst_count_o, 0);
        chk("arst_data", {rec_if.rec_flags, rec_if.rec_reg, rec_if.rec_wdata,
                          rec_if.rec_addr, rec_if.rec_mdata, rec_if.rec_cycle}, 0);
        reset_dut();
        rec_if.rec_ready = 1;
        ev(1, 4'b0001, 3'd0, 16'h0000, 16'h0040, 16'h1111, 16'h0000, 16'h1111);
        tick();
        chk("drain_e", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/commit_trace_unit.md
# commit_trace_unit

Synthesizable commit-trace and performance-counter unit. Each cycle it samples the processor's writeback/memory commit signals, packs every committing event into a trace record, buffers records in a FIFO, and drains them over a valid/ready stream to an off-core trace sink. It also keeps the run statistics: cycle, instruction, and I/D-cache request and hit counts. It is the in-hardware producer of the same commit stream the simulation trace monitor consumes, and it sits beside the core in `proc_hier`, fed by the WB-stage register-write, MEM-stage and cache signals.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `CNT_W`, 32: width of all statistics counters.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `reg_wr`  in  1  register-file write this cycle.
- `wr_reg`  in  3  destination register.
- `wr_data`  in  16  register write data.
- `mem_rd`  in  1  load committing.
- `mem_wr`  in  1  store committing.
- `mem_addr`  in  16  memory address.
- `mem_wdata`  in  16  store data.
- `mem_rdata`  in  16  load data.
- `halt`  in  1  HALT committing.
- `icache_req`, `icache_hit`, `dcache_req`, `dcache_hit`  in  1 each  cache event strobes.
- `rec_valid`  out  1  head record valid.
- `rec_ready`  in  1  sink accepts the head record.
- `rec_flags`  out  4  {halt, reg_wr, mem_rd, mem_wr} of the record.
- `rec_reg`  out  3  recorded `wr_reg`.
- `rec_wdata`  out  16  recorded `wr_data`.
- `rec_addr`  out  16  recorded `mem_addr`.
- `rec_mdata`  out  16  `mem_wdata` if `mem_wr`, else `mem_rdata`.
- `rec_cycle`  out  16  low 16 bits of `cycle_count` at capture.
- `full`  out  1  FIFO holds `DEPTH` records; the core uses it as a stall request.
- `overflow`  out  1  sticky; a record was dropped.
- `done`  out  1  halt captured and FIFO empty.
- `cycle_count`, `inst_count`, `icache_req_cnt`, `icache_hit_cnt`, `dcache_req_cnt`, `dcache_hit_cnt`  out  `CNT_W` each  statistics.

## Operation
- An event occurs when `!halted & (halt | reg_wr | mem_rd | mem_wr)`. Each event produces exactly one record holding all sampled fields, including fields whose flag is 0.
- A load that also writes a register is one record, with both `reg_wr` and `mem_rd` flags set.
- If `mem_rd` and `mem_wr` are both asserted, both flags are recorded and `rec_mdata` takes `mem_wdata`.
- The FIFO is show-ahead. The `rec_*` outputs always reflect the head entry and hold their value while `rec_valid & !rec_ready`.
- A pop happens when `rec_valid & rec_ready`.
- A push happens on an event when the FIFO count is below `DEPTH`, or when the FIFO is full and a pop occurs in the same cycle.
- A push with no pop on an empty FIFO is normal; a simultaneous push and pop leaves the count unchanged.
- An event with the FIFO full and no pop is dropped, and `overflow` is set to 1 until reset.
- State `RUN` → `HALTED` on the edge where an event with `halt=1` is sampled. The transition happens even if that record is dropped.
- In `HALTED`, all inputs except `rec_ready` are ignored: no pushes, and every counter is frozen. The FIFO keeps draining.
- `done = halted & (count==0)`.
- Counters advance only in `RUN`, including the halting cycle itself, and wrap modulo 2^`CNT_W`:
  - `cycle_count`: +1 every cycle.
  - `inst_count`: +1 when `halt | reg_wr | mem_wr`. Loads count through their `reg_wr`.
  - The four cache counters: +1 on their respective strobe.
- `rec_cycle` captures `cycle_count[15:0]` before that edge's increment. The first cycle after reset is therefore stamped 0.
- Read and write pointers are log2(`DEPTH`) bits and wrap naturally. The count is log2(`DEPTH`)+1 bits.

## Timing
- Reset (asynchronous, takes effect immediately) sets:
  - state `RUN`, all pointers, count and counters to 0;
  - `rec_valid=0`, `full=0`, `overflow=0`, `done=0`;
  - `rec_*` data outputs to 0.
- Reset asserted mid-drain discards all buffered records.
- Push-to-valid latency is 1 cycle: an event sampled at edge N makes `rec_valid` high after edge N when the FIFO was empty.
- Pop-to-next-head latency is 0: the next entry appears after the same edge that pops.
- `full` and `done` are registered-state decodes, valid the cycle after the causing edge.
- A statistics counter reflects an event after the edge that samples it.

## Test plan
- Reset, then store `mem_wr=1, mem_addr=0x0010, mem_wdata=0xBEEF` in cycle 0, `rec_ready=1` → one record with flags 0001, addr 0x0010, mdata 0xBEEF, `rec_cycle=0`; `inst_count=1`.
- Load with `reg_wr=1, wr_reg=3, wr_data=0x1234, mem_rd=1, mem_rdata=0x1234` → a single record with flags 0110, reg 3, mdata 0x1234; `inst_count` +1.
- `rec_ready=0`, events on 9 consecutive cycles with `DEPTH=8` → `full=1` after the 8th; the 9th is dropped and `overflow=1`. Then raise `rec_ready` → 8 records drain in order with stamps 0..7.
- Full FIFO, event and `rec_ready=1` in the same cycle → push is accepted, count stays 8, `overflow` stays 0.
- `halt=1` with 3 records queued, then further `reg_wr` pulses → no new records, counters frozen. `done=1` only after the 4th record (the halt, flags 1000) pops.
- Assert `rst` while 5 records are queued and `overflow=1` → all outputs return to 0 immediately, without waiting for `clk`.
